bicubic_tap_accum: RTL and testbench

Parametrised four-tap bicubic accumulator for the interpolation datapath. It takes four neighbouring pixel samples per channel plus four signed fixed-point kernel coefficients and produces the rounded, clamped weighted sum for every channel. Inputs and outputs use valid/ready handshakes, and the block runs as a three-stage stallable pipeline. It sits between the coefficient/line-buffer fetch logic and the output pixel packer; the horizontal and vertical passes use one instance each.

---
 rtl/bicubic_pkg.sv | 24 ++
 rtl/bicubic_round_clamp.sv | 49 ++++
 rtl/bicubic_tap_accum.sv | 98 +++++++++
 tb/tb_bicubic_tap_accum.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic tap accumulator: default widths, derived
// product/accumulator widths and the coefficient unity value.
package bicubic_pkg;

  localparam int CH_DEF     = 3;
  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 11;
  localparam int FRAC_W_DEF = 8;

  // A zero-extended pixel times a signed coefficient needs one extra sign bit.
  function automatic int prod_width(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  // Two more bits cover the sum of four products.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 3;
  endfunction

  localparam int PROD_W = prod_width(DATA_W_DEF, COEF_W_DEF);
  localparam int ACC_W  = acc_width(DATA_W_DEF, COEF_W_DEF);
  localparam int UNITY  = 1 << FRAC_W_DEF;

endpackage

// File: rtl/bicubic_round_clamp.sv
// Round-half-up and (with BICUBIC_SAT_EN) clamp of one channel's accumulator.
// Without BICUBIC_SAT_EN the result wraps and sat is tied low.
module bicubic_round_clamp #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 22
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] pix,
  output logic                     sat
);

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_W - 1);

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] rs;

  // One guard bit keeps the rounding bias from overflowing the accumulator.
  assign biased = (ACC_W+1)'(acc) + HALF;
  assign rs     = biased >>> FRAC_W;

`ifdef BICUBIC_SAT_EN
  logic neg;
  logic over;

  assign neg  = rs[ACC_W];
  assign over = !neg && (|rs[ACC_W-1:DATA_W]);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pix = rs[DATA_W-1:0];
    sat = 1'b0;
    if (neg) begin
      pix = '0;
      sat = 1'b1;
    end else if (over) begin
      pix = '1;
      sat = 1'b1;
    end
  end
`else
  logic unused_hi;

  assign pix       = rs[DATA_W-1:0];
  assign sat       = 1'b0;
  assign unused_hi = ^rs[ACC_W:DATA_W];
`endif

endmodule

// File: rtl/bicubic_tap_accum.sv
// Three-stage stallable four-tap bicubic accumulator (products, pair sums,
// round/clamp). Clamping is enabled by defining BICUBIC_SAT_EN.
module bicubic_tap_accum
  import bicubic_pkg::*;
#(
  parameter int CH     = CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*CH*DATA_W-1:0]   pix_in,
  input  logic [4*COEF_W-1:0]      coef_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH*DATA_W-1:0]     pix_out,
  output logic [CH-1:0]            sat_flag
);

  localparam int PW = prod_width(DATA_W, COEF_W);
  localparam int AW = acc_width(DATA_W, COEF_W);

  logic v1, v2, v3;
  logic ce;

  logic signed [PW-1:0] px_ext [4][CH];
  logic signed [PW-1:0] cf_ext [4];
  logic signed [PW-1:0] prod   [4][CH];
  logic signed [AW-1:0] pair01 [CH];
  logic signed [AW-1:0] pair23 [CH];
  logic signed [AW-1:0] acc    [CH];
  logic [DATA_W-1:0]    rc_pix [CH];
  logic [CH-1:0]        rc_sat;

  // One enable for the whole pipe: it only stalls when the output is held.
  assign ce        = !v3 || out_ready;
  assign in_ready  = ce;
  assign out_valid = v3;

  always_comb begin
    for (int t = 0; t < 4; t++) begin
      cf_ext[t] = PW'($signed(coef_in[t*COEF_W +: COEF_W]));
      for (int c = 0; c < CH; c++)
        px_ext[t][c] = PW'({1'b0, pix_in[(t*CH+c)*DATA_W +: DATA_W]});
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++)
      acc[c] = pair01[c] + pair23[c];
  end

  for (genvar g = 0; g < CH; g++) begin : g_rc
    bicubic_round_clamp #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (AW)
    ) u_rc (
      .acc (acc[g]),
      .pix (rc_pix[g]),
      .sat (rc_sat[g])
    );
  end

  // NOTE: the datapath registers are reset too, because pix_out must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      pix_out  <= '0;
      sat_flag <= '0;
      for (int c = 0; c < CH; c++) begin
        pair01[c] <= '0;
        pair23[c] <= '0;
        for (int t = 0; t < 4; t++)
          prod[t][c] <= '0;
      end
    end else if (ce) begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
      v1 <= in_valid && in_ready;
      v2 <= v1;
      v3 <= v2;
      for (int c = 0; c < CH; c++) begin
        for (int t = 0; t < 4; t++)
          prod[t][c] <= px_ext[t][c] * cf_ext[t];
        pair01[c] <= AW'(prod[0][c]) + AW'(prod[1][c]);
        pair23[c] <= AW'(prod[2][c]) + AW'(prod[3][c]);
        pix_out[c*DATA_W +: DATA_W] <= rc_pix[c];
      end
      sat_flag <= rc_sat;
    end
  end

endmodule

// File: tb/tb_bicubic_tap_accum.sv
// Self-checking bench for bicubic_tap_accum: directed vector table, random
// backpressure stream against an arithmetic reference model, and mid-stream reset.
module tb_bicubic_tap_accum;

  localparam int CH = 3;
  localparam int DW = 8;
  localparam int CW = 11;
  localparam int FW = 8;

  typedef struct packed {
    logic [4*CW-1:0]    coef;
    logic [4*CH*DW-1:0] pix;
    logic [CH*DW-1:0]   exp_pix;
    logic [CH-1:0]      exp_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4*CH*DW-1:0] pix_in = '0;
  logic [4*CW-1:0] coef_in = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [CH*DW-1:0] pix_out;
  logic [CH-1:0] sat_flag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bicubic_tap_accum #(.CH(CH), .DATA_W(DW), .COEF_W(CW), .FRAC_W(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pix_in    (pix_in),
    .coef_in   (coef_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pix_out   (pix_out),
    .sat_flag  (sat_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4*CW-1:0] mk_coef(input int c0, input int c1, input int c2, input int c3);
    logic [CW-1:0] a0, a1, a2, a3;
    a0 = CW'(c0); a1 = CW'(c1); a2 = CW'(c2); a3 = CW'(c3);
    return {a3, a2, a1, a0};
  endfunction

  // Channel-major arguments: tN = {ch2, ch1, ch0} for tap N.
  function automatic logic [4*CH*DW-1:0] mk_pix(input logic [23:0] t0, input logic [23:0] t1,
                                                input logic [23:0] t2, input logic [23:0] t3);
    return {t3, t2, t1, t0};
  endfunction

  // Reference: integer weighted sum, floor((acc + half) / unity), then clamp or wrap.
  function automatic void ref_model(input logic [4*CW-1:0] coef, input logic [4*CH*DW-1:0] pix,
                                    output logic [CH*DW-1:0] opix, output logic [CH-1:0] osat);
    for (int c = 0; c < CH; c++) begin
      int acc;
      int r;
      acc = 0;
      for (int t = 0; t < 4; t++)
        acc += int'(pix[(t*CH+c)*DW +: DW]) * int'($signed(coef[t*CW +: CW]));
      r = (acc + (1 << (FW-1))) >>> FW;
`ifdef BICUBIC_SAT_EN
      if (r < 0) begin
        opix[c*DW +: DW] = '0;
        osat[c] = 1'b1;
      end else if (r > (1 << DW) - 1) begin
        opix[c*DW +: DW] = '1;
        osat[c] = 1'b1;
      end else begin
        opix[c*DW +: DW] = r[DW-1:0];
        osat[c] = 1'b0;
      end
`else
      opix[c*DW +: DW] = r[DW-1:0];
      osat[c] = 1'b0;
`endif
    end
  endfunction

  vec_t vecs[6];
  logic [CH*DW+CH-1:0] sb[$];

  initial begin
    logic [CH*DW-1:0] mp;
    logic [CH-1:0] ms;
    logic [CH*DW+CH-1:0] exp_e;
    logic prev_stall;
    logic [CH*DW+CH-1:0] prev_out;
    int sent, rcvd, cyc;
    logic stale;

    // Directed vectors with hand-derived results.
    vecs[0].coef = mk_coef(0, 256, 0, 0);
    vecs[0].pix  = mk_pix({8'd9, 8'd9, 8'd9}, {8'd0, 8'd17, 8'd200}, {8'd70, 8'd60, 8'd50}, {8'd3, 8'd2, 8'd1});
    vecs[0].exp_pix = {8'd0, 8'd17, 8'd200};
    vecs[0].exp_sat = 3'b000;
    vecs[1].coef = mk_coef(-16, 144, 144, -16);
    vecs[1].pix  = mk_pix({3{8'd100}}, {3{8'd100}}, {3{8'd100}}, {3{8'd100}});
    vecs[1].exp_pix = {3{8'd100}};
    vecs[1].exp_sat = 3'b000;
    vecs[2].coef = mk_coef(-32, 160, 160, -32);
    vecs[2].pix  = mk_pix({8'd10, 8'd255, 8'd0}, {8'd10, 8'd0, 8'd255}, {8'd10, 8'd0, 8'd255}, {8'd10, 8'd255, 8'd0});
`ifdef BICUBIC_SAT_EN
    vecs[2].exp_pix = {8'd10, 8'd0, 8'd255};
    vecs[2].exp_sat = 3'b011;
`else
    vecs[2].exp_pix = {8'd10, 8'd192, 8'd63};
    vecs[2].exp_sat = 3'b000;
`endif
    vecs[3].coef = mk_coef(128, 128, 0, 0);
    vecs[3].pix  = mk_pix({8'd0, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd2}, {3{8'd77}}, {3{8'd77}});
    vecs[3].exp_pix = {8'd1, 8'd1, 8'd2};
    vecs[3].exp_sat = 3'b000;
    vecs[4].coef = mk_coef(-128, 0, 0, 0);
    vecs[4].pix  = mk_pix({8'd0, 8'd3, 8'd1}, {3{8'd200}}, {3{8'd200}}, {3{8'd200}});
`ifdef BICUBIC_SAT_EN
    vecs[4].exp_pix = {8'd0, 8'd0, 8'd0};
    vecs[4].exp_sat = 3'b010;
`else
    vecs[4].exp_pix = {8'd0, 8'd255, 8'd0};
    vecs[4].exp_sat = 3'b000;
`endif
    vecs[5].coef = mk_coef(1023, 1023, 1023, 1023);
    vecs[5].pix  = mk_pix({8'd1, 8'd0, 8'd255}, {8'd1, 8'd0, 8'd255}, {8'd1, 8'd0, 8'd255}, {8'd1, 8'd0, 8'd255});
`ifdef BICUBIC_SAT_EN
    vecs[5].exp_pix = {8'd16, 8'd0, 8'd255};
    vecs[5].exp_sat = 3'b001;
`else
    vecs[5].exp_pix = {8'd16, 8'd0, 8'd236};
    vecs[5].exp_sat = 3'b000;
`endif

    // Reset state.
    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_pix_out", 32'(pix_out), 32'd0);
    check("reset_sat_flag", 32'(sat_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed table: one tap set at a time, exact latency check.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      coef_in   = vecs[i].coef;
      pix_in    = vecs[i].pix;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1", i), 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_lat2", i), 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_pix", i), 32'(pix_out), 32'(vecs[i].exp_pix));
      check($sformatf("vec%0d_sat", i), 32'(sat_flag), 32'(vecs[i].exp_sat));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_drain", i), 32'(out_valid), 32'd0);
    end

    // Random stream with random backpressure, checked against the reference model.
    sent = 0;
    rcvd = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    for (cyc = 0; cyc < 600 && (sent < 12 || rcvd < 12); cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < 55);
      in_valid  = (sent < 12) && ($urandom_range(0, 99) < 75);
      coef_in   = mk_coef(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                          int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
      for (int k = 0; k < 4*CH; k++)
        pix_in[k*DW +: DW] = DW'($urandom_range(0, 255));
      #1;
      check("stream_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("stream_stall_valid", 32'(out_valid), 32'd1);
        check("stream_stall_hold", 32'({sat_flag, pix_out}), 32'(prev_out));
      end
      if (in_valid && in_ready) begin
        ref_model(coef_in, pix_in, mp, ms);
        sb.push_back({ms, mp});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("stream_unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          exp_e = sb.pop_front();
          check($sformatf("stream_res%0d", rcvd), 32'({sat_flag, pix_out}), 32'(exp_e));
        end
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {sat_flag, pix_out};
    end
    in_valid = 1'b0;
    check("stream_received_all", 32'(rcvd), 32'd12);

    // Mid-stream reset with three results in flight.
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      coef_in  = mk_coef(0, 256, 0, 0);
      pix_in   = {4*CH{8'(8'd40 + 8'(i))}};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pix_out", 32'(pix_out), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    check("rst_no_stale", 32'(stale), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
